// File: rtl/osd_text_writer_if.sv
// Command handshake into the OSD text writer.
// Master issues put/hex/clear commands, slave returns ready.
interface osd_text_writer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_col;
  logic [4:0]  cmd_row;
  logic [15:0] cmd_data;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_col,
    output cmd_row,
    output cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_col,
    input  cmd_row,
    input  cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/osd_text_writer.sv
// Serialises text commands into one OSD char RAM write per clock.
// Write port outputs are registered; first write lands the cycle after accept.
module osd_text_writer #(
  parameter int          COLS       = 40,
  parameter int          ROWS       = 30,
  parameter logic [7:0]  BLANK_CHAR = 8'h20,
  parameter int          ADDR_W     = 11
) (
  input  logic              clk,
  input  logic              reset_n,
  osd_text_writer_if.slave  cmd,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_CLR  = 2'd2;

  localparam logic [1:0] OP_PUTC  = 2'd0;
  localparam logic [1:0] OP_HEX8  = 2'd1;
  localparam logic [1:0] OP_HEX16 = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam int              CELLS  = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] COLS_A = ADDR_W'(COLS);

  logic [1:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [15:0]       data_q, data_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdat_q, wdat_d;
  logic              wen_q, wen_d;
  logic              err_q, err_d;

  logic              accept;
  logic              bad_pos;
  logic [15:0]       aligned;
  logic [ADDR_W-1:0] start;

  function automatic logic [7:0] hex_glyph(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // Hex data is kept MS-nibble aligned at [15:12]; PUTC uses [7:0].
  function automatic logic [7:0] glyph(input logic [1:0] op,
                                       input logic [15:0] d);
    return (op == OP_PUTC) ? d[7:0] : hex_glyph(d[15:12]);
  endfunction

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST) ? '0 : a + 1'b1;
  endfunction

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign accept  = cmd.cmd_valid && (state_q == S_IDLE);
  assign bad_pos = (32'(cmd.cmd_col) >= 32'(COLS)) ||
                   (32'(cmd.cmd_row) >= 32'(ROWS));
  assign aligned = (cmd.cmd_op == OP_HEX8) ?
                   {cmd.cmd_data[7:0], 8'h00} : cmd.cmd_data;
  assign start   = ADDR_W'(cmd.cmd_row) * COLS_A + ADDR_W'(cmd.cmd_col);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    wen_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd.cmd_op == OP_CLEAR) begin
            state_d = S_CLR;
            addr_d  = '0;
            wdat_d  = BLANK_CHAR;
            wen_d   = 1'b1;
          end else if (bad_pos) begin
            err_d = 1'b1;
          end else begin
            state_d = S_EMIT;
            op_d    = cmd.cmd_op;
            addr_d  = start;
            wdat_d  = glyph(cmd.cmd_op, aligned);
            data_d  = {aligned[11:0], 4'h0};
            wen_d   = 1'b1;
            unique case (1'b1)
              cmd.cmd_op == OP_HEX8:  cnt_d = 2'd1;
              cmd.cmd_op == OP_HEX16: cnt_d = 2'd3;
              default:                cnt_d = 2'd0;
            endcase
          end
        end
      end
      S_EMIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_IDLE;
        end else begin
          addr_d = next_addr(addr_q);
          wdat_d = glyph(op_q, data_q);
          data_d = {data_q[11:0], 4'h0};
          cnt_d  = cnt_q - 2'd1;
          wen_d  = 1'b1;
        end
      end
      S_CLR: begin
        if (addr_q == LAST) begin
          state_d = S_IDLE;
        end else begin
          addr_d = next_addr(addr_q);
          wdat_d = BLANK_CHAR;
          wen_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_PUTC;
      data_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      wen_q   <= wen_d;
      err_q   <= err_d;
    end
  end

  assign wr_addr = addr_q;
  assign wr_data = wdat_q;
  assign wr_en   = wen_q;
  assign busy    = (state_q != S_IDLE);
  assign cmd_err = err_q;

endmodule
